qspi_bus_arbiter: RTL and testbench

Shares the single QSPI controller (flash CS, RAM_A CS, RAM_B CS on the uio pins) between the CPU instruction-fetch port and the data port of tt_um_techhu_rv32_trial. It decodes a 25-bit address into a chip select and serialises one transaction at a time. Data has priority, and an anti-starvation counter keeps instruction fetch progressing. Writes to flash are rejected locally and never reach the bus.

---
 rtl/qspi_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: shares one QSPI controller between ifetch and data ports.
// Optional grant/wait counters are built when QSPI_ARB_PERF_EN is defined.
module qspi_bus_arbiter #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [24:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_len,
   input  logic [24:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        q_start,
   output logic [1:0]  q_sel,
   output logic [23:0] q_addr,
   output logic        q_we,
   output logic [1:0]  q_len,
   output logic [31:0] q_wdata,
   input  logic        q_done,
   input  logic [31:0] q_rdata
`ifdef QSPI_ARB_PERF_EN
   ,
   output logic [15:0] perf_if_grants,
   output logic [15:0] perf_d_grants,
   output logic [15:0] perf_if_wait
`endif
);

   localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ERR
   } state_t;

   state_t      state, state_n;
   logic        owner_d, owner_d_n;
   logic        live, live_n;
   logic [3:0]  streak, streak_n;
   logic        grant_if, grant_d;
   logic        owner_req;

   logic        if_done_n, d_done_n, d_err_n;
   logic [31:0] if_rdata_n, d_rdata_n;
   logic [1:0]  q_sel_n;
   logic [23:0] q_addr_n;
   logic        q_we_n;
   logic [1:0]  q_len_n;
   logic [31:0] q_wdata_n;

   function automatic logic [1:0] dec_sel(input logic [24:0] a);
      logic [1:0] s;
      unique case (1'b1)
         !a[24]:          s = 2'd0;
         a[24] && !a[23]: s = 2'd1;
         default:         s = 2'd2;
      endcase
      return s;
   endfunction

   function automatic logic [23:0] dec_addr(input logic [24:0] a);
      return a[24] ? {1'b0, a[22:0]} : a[23:0];
   endfunction

   assign q_start   = (state == ISSUE);
   assign owner_req = owner_d ? d_req : if_req;

   always_comb begin
      state_n    = state;
      owner_d_n  = owner_d;
      live_n     = live;
      streak_n   = streak;
      grant_if   = 1'b0;
      grant_d    = 1'b0;
      if_done_n  = 1'b0;
      d_done_n   = 1'b0;
      d_err_n    = 1'b0;
      if_rdata_n = if_rdata;
      d_rdata_n  = d_rdata;
      q_sel_n    = q_sel;
      q_addr_n   = q_addr;
      q_we_n     = q_we;
      q_len_n    = q_len;
      q_wdata_n  = q_wdata;

      unique case (state)
         IDLE: begin
            if (!if_req) streak_n = '0;
            // Skip arbitration while a done pulse is out: the requester
            // still holds req this cycle for the transaction just finished.
            if (!(if_done || d_done)) begin
               if (if_req && (!d_req || streak == MAX_STREAK))
                  grant_if = 1'b1;
               else if (d_req)
                  grant_d = 1'b1;
            end
            if (grant_if) begin
               streak_n  = '0;
               owner_d_n = 1'b0;
               live_n    = 1'b1;
               q_sel_n   = dec_sel(if_addr);
               q_addr_n  = dec_addr(if_addr);
               q_we_n    = 1'b0;
               q_len_n   = 2'd3;
               q_wdata_n = '0;
               state_n   = ISSUE;
            end else if (grant_d) begin
               if (if_req && streak < MAX_STREAK)
                  streak_n = streak + 4'd1;
               if (d_we && dec_sel(d_addr) == 2'd0) begin
                  d_done_n  = 1'b1;
                  d_err_n   = 1'b1;
                  d_rdata_n = '0;
                  state_n   = ERR;
               end else begin
                  owner_d_n = 1'b1;
                  live_n    = 1'b1;
                  q_sel_n   = dec_sel(d_addr);
                  q_addr_n  = dec_addr(d_addr);
                  q_we_n    = d_we;
                  q_len_n   = d_len;
                  q_wdata_n = d_wdata;
                  state_n   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!owner_req) live_n = 1'b0;
            state_n = WAIT;
         end
         WAIT: begin
            if (!owner_req) live_n = 1'b0;
            if (q_done) begin
               state_n = IDLE;
               if (live && owner_req) begin
                  if (owner_d) begin
                     d_done_n  = 1'b1;
                     d_rdata_n = q_rdata;
                  end else begin
                     if_done_n  = 1'b1;
                     if_rdata_n = q_rdata;
                  end
               end
            end
         end
         ERR: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner_d  <= 1'b0;
         live     <= 1'b0;
         streak   <= '0;
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         d_err    <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
         q_sel    <= '0;
         q_addr   <= '0;
         q_we     <= 1'b0;
         q_len    <= '0;
         q_wdata  <= '0;
      end else begin
         state    <= state_n;
         owner_d  <= owner_d_n;
         live     <= live_n;
         streak   <= streak_n;
         if_done  <= if_done_n;
         d_done   <= d_done_n;
         d_err    <= d_err_n;
         if_rdata <= if_rdata_n;
         d_rdata  <= d_rdata_n;
         q_sel    <= q_sel_n;
         q_addr   <= q_addr_n;
         q_we     <= q_we_n;
         q_len    <= q_len_n;
         q_wdata  <= q_wdata_n;
      end
   end

`ifdef QSPI_ARB_PERF_EN
   logic serving_if;
   assign serving_if = (state == ISSUE || state == WAIT) && !owner_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_if_grants <= '0;
         perf_d_grants  <= '0;
         perf_if_wait   <= '0;
      end else begin
         if (grant_if && perf_if_grants != 16'hFFFF)
            perf_if_grants <= perf_if_grants + 16'd1;
         if (grant_d && perf_d_grants != 16'hFFFF)
            perf_d_grants <= perf_d_grants + 16'd1;
         if (if_req && !serving_if && perf_if_wait != 16'hFFFF)
            perf_if_wait <= perf_if_wait + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// tb_qspi_bus_arbiter: scoreboard bench with a QSPI controller model.
// Perf counter checks are built when QSPI_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module tb_qspi_bus_arbiter;

   typedef struct packed {
      logic [1:0]  sel;
      logic [23:0] addr;
      logic        we;
      logic [1:0]  len;
      logic [31:0] wdata;
   } qtxn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [24:0] if_addr = '0;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [1:0]  d_len = '0;
   logic [24:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done;
   logic        d_err;
   logic [31:0] d_rdata;
   logic        q_start;
   logic [1:0]  q_sel;
   logic [23:0] q_addr;
   logic        q_we;
   logic [1:0]  q_len;
   logic [31:0] q_wdata;
   logic        q_done;
   logic [31:0] q_rdata;
`ifdef QSPI_ARB_PERF_EN
   logic [15:0] perf_if_grants, perf_d_grants, perf_if_wait;
`endif

   qtxn_t       exp_q[$];
   logic [31:0] rd_q[$];
   int          n_pass = 0;
   int          n_checks = 0;

   int          mdl_cnt = 0;
   int          n_starts = 0;
   int          n_overlap = 0;
   logic [31:0] mdl_data = '0;
   logic [31:0] mdl_next = '0;

   always #5 clk = ~clk;

   qspi_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_len(d_len),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .q_start(q_start), .q_sel(q_sel), .q_addr(q_addr),
      .q_we(q_we), .q_len(q_len), .q_wdata(q_wdata),
      .q_done(q_done), .q_rdata(q_rdata)
`ifdef QSPI_ARB_PERF_EN
      ,
      .perf_if_grants(perf_if_grants),
      .perf_d_grants(perf_d_grants),
      .perf_if_wait(perf_if_wait)
`endif
   );

   // Controller model: q_done five cycles after each q_start.
   initial begin
      q_done  = 1'b0;
      q_rdata = '0;
      forever begin
         @(negedge clk);
         q_done = 1'b0;
         if (!rst_n) begin
            mdl_cnt = 0;
         end else begin
            if (mdl_cnt > 0) begin
               mdl_cnt--;
               if (mdl_cnt == 0) begin
                  q_done  = 1'b1;
                  q_rdata = mdl_data;
               end
            end
            if (q_start) begin
               n_starts++;
               if (mdl_cnt != 0 || q_done) n_overlap++;
               mdl_cnt  = 5;
               mdl_data = mdl_next;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick;
      n_checks++;
      if ({q_start, if_done, d_done, d_err} !== 4'b0000)
         $display("FAIL reset_pulses got %b want 0000",
                  {q_start, if_done, d_done, d_err});
      else n_pass++;
      n_checks++;
      if ({q_sel, q_addr, q_we, q_len, q_wdata} !== 61'd0)
         $display("FAIL reset_payload got %h want 0",
                  {q_sel, q_addr, q_we, q_len, q_wdata});
      else n_pass++;
      n_checks++;
      if ({if_rdata, d_rdata} !== 64'd0)
         $display("FAIL reset_rdata got %h want 0", {if_rdata, d_rdata});
      else n_pass++;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_ifetch;
      qtxn_t e;
      int lat = 0;
      logic [31:0] r;
      mdl_next = 32'h00000513;
      exp_q.push_back({2'd0, 24'h000100, 1'b0, 2'd3, 32'd0});
      rd_q.push_back(32'h00000513);
      if_addr = 25'h0000100;
      if_req  = 1'b1;
      tick;
      n_checks++;
      if (q_start !== 1'b1)
         $display("FAIL if_start got %b want 1", q_start);
      else n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if ({q_sel, q_addr, q_we, q_len, q_wdata} !== e)
         $display("FAIL if_payload got %h want %h",
                  {q_sel, q_addr, q_we, q_len, q_wdata}, e);
      else n_pass++;
      tick;
      lat = 1;
      n_checks++;
      if ({q_start, q_addr} !== {1'b0, 24'h000100})
         $display("FAIL if_hold got %h want %h",
                  {q_start, q_addr}, {1'b0, 24'h000100});
      else n_pass++;
      for (int i = 0; i < 40 && !if_done; i++) begin
         tick;
         lat++;
      end
      n_checks++;
      if (if_done !== 1'b1)
         $display("FAIL if_done_timeout got %b want 1", if_done);
      else n_pass++;
      n_checks++;
      if (lat !== 6)
         $display("FAIL if_latency got %0d want 6", lat);
      else n_pass++;
      r = rd_q.pop_front();
      n_checks++;
      if (if_rdata !== r)
         $display("FAIL if_rdata got %h want %h", if_rdata, r);
      else n_pass++;
      if_req = 1'b0;
      tick;
   endtask

   task automatic test_data;
      qtxn_t e;
      logic [31:0] r;
      exp_q.push_back({2'd1, 24'h000040, 1'b1, 2'd3, 32'hDEADBEEF});
      d_addr = 25'h1000040; d_we = 1'b1; d_len = 2'd3;
      d_wdata = 32'hDEADBEEF; d_req = 1'b1;
      tick;
      e = exp_q.pop_front();
      n_checks++;
      if ({q_start, q_sel, q_addr, q_we, q_len, q_wdata} !== {1'b1, e})
         $display("FAIL dw_payload got %h want %h",
                  {q_start, q_sel, q_addr, q_we, q_len, q_wdata}, {1'b1, e});
      else n_pass++;
      for (int i = 0; i < 40 && !d_done; i++) tick;
      n_checks++;
      if ({d_done, d_err} !== 2'b10)
         $display("FAIL dw_done got %b want 10", {d_done, d_err});
      else n_pass++;
      d_req = 1'b0;
      tick;
      mdl_next = 32'hCAFEF00D;
      exp_q.push_back({2'd2, 24'h000010, 1'b0, 2'd1, 32'h12345678});
      rd_q.push_back(32'hCAFEF00D);
      d_addr = 25'h1800010; d_we = 1'b0; d_len = 2'd1;
      d_wdata = 32'h12345678; d_req = 1'b1;
      tick;
      e = exp_q.pop_front();
      n_checks++;
      if ({q_start, q_sel, q_addr, q_we, q_len, q_wdata} !== {1'b1, e})
         $display("FAIL dr_payload got %h want %h",
                  {q_start, q_sel, q_addr, q_we, q_len, q_wdata}, {1'b1, e});
      else n_pass++;
      for (int i = 0; i < 40 && !d_done; i++) tick;
      r = rd_q.pop_front();
      n_checks++;
      if ({d_done, d_err, d_rdata} !== {2'b10, r})
         $display("FAIL dr_rdata got %h want %h",
                  {d_done, d_err, d_rdata}, {2'b10, r});
      else n_pass++;
      d_req = 1'b0;
      tick;
   endtask

   task automatic test_flash_write;
      int base = n_starts;
      d_addr = 25'h0000020; d_we = 1'b1; d_len = 2'd3;
      d_wdata = 32'h11111111; d_req = 1'b1;
      tick;
      n_checks++;
      if ({d_done, d_err, q_start, d_rdata} !== {3'b110, 32'd0})
         $display("FAIL fw_err got %h want %h",
                  {d_done, d_err, q_start, d_rdata}, {3'b110, 32'd0});
      else n_pass++;
      d_req = 1'b0;
      tick;
      n_checks++;
      if ({d_done, d_err} !== 2'b00)
         $display("FAIL fw_pulse got %b want 00", {d_done, d_err});
      else n_pass++;
      repeat (7) tick;
      n_checks++;
      if (n_starts !== base)
         $display("FAIL fw_no_start got %0d want %0d", n_starts, base);
      else n_pass++;
   endtask

   task automatic test_drop;
      int dd = 0;
      bit seen = 1'b0;
      bit done = 1'b0;
      logic [1:0] sel2 = 2'd3;
      logic [31:0] r;
      mdl_next = 32'h00A0B0C0;
      rd_q.push_back(32'h00A0B0C0);
      d_addr = 25'h1000100; d_we = 1'b0; d_len = 2'd3; d_wdata = '0;
      if_addr = 25'h0000400;
      d_req = 1'b1; if_req = 1'b1;
      tick;
      n_checks++;
      if ({q_start, q_sel} !== 3'b101)
         $display("FAIL drop_first got %b want 101", {q_start, q_sel});
      else n_pass++;
      tick;
      d_req = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick;
         if (d_done) dd++;
         if (q_start && !seen) begin
            seen = 1'b1;
            sel2 = q_sel;
         end
         if (if_done) done = 1'b1;
      end
      if_req = 1'b0;
      n_checks++;
      if (dd !== 0)
         $display("FAIL drop_no_done got %0d want 0", dd);
      else n_pass++;
      n_checks++;
      if (sel2 !== 2'd0)
         $display("FAIL drop_next_sel got %0d want 0", sel2);
      else n_pass++;
      r = rd_q.pop_front();
      n_checks++;
      if ({done, if_rdata} !== {1'b1, r})
         $display("FAIL drop_if got %h want %h", {done, if_rdata}, {1'b1, r});
      else n_pass++;
      tick;
   endtask

   task automatic test_reset_mid;
      qtxn_t e;
      logic [31:0] r;
      mdl_next = 32'h55AA55AA;
      if_addr = 25'h0000300;
      if_req = 1'b1;
      tick;
      n_checks++;
      if (q_start !== 1'b1)
         $display("FAIL rm_start got %b want 1", q_start);
      else n_pass++;
      tick;
      tick;
      rst_n = 1'b0;
      if_req = 1'b0;
      tick;
      n_checks++;
      if ({q_start, if_done, d_done, d_err, q_sel, q_addr, q_we, q_len,
           q_wdata, if_rdata, d_rdata} !== 129'd0)
         $display("FAIL rm_reset got %h want 0",
                  {q_start, if_done, d_done, d_err, q_sel, q_addr, q_we,
                   q_len, q_wdata, if_rdata, d_rdata});
      else n_pass++;
      rst_n = 1'b1;
      tick;
      mdl_next = 32'h13579BDF;
      exp_q.push_back({2'd2, 24'h000020, 1'b0, 2'd3, 32'd0});
      rd_q.push_back(32'h13579BDF);
      if_addr = 25'h1800020;
      if_req = 1'b1;
      tick;
      e = exp_q.pop_front();
      n_checks++;
      if ({q_start, q_sel, q_addr, q_we, q_len, q_wdata} !== {1'b1, e})
         $display("FAIL rm_fresh got %h want %h",
                  {q_start, q_sel, q_addr, q_we, q_len, q_wdata}, {1'b1, e});
      else n_pass++;
      for (int i = 0; i < 40 && !if_done; i++) tick;
      r = rd_q.pop_front();
      n_checks++;
      if ({if_done, if_rdata} !== {1'b1, r})
         $display("FAIL rm_rdata got %h want %h",
                  {if_done, if_rdata}, {1'b1, r});
      else n_pass++;
      if_req = 1'b0;
      tick;
   endtask

   task automatic test_back_to_back;
      logic [1:0] order[$];
      int grants = 0;
      int w = 0;
      int post = 0;
      int ov0;
      bit act = 1'b0;
      bit qdp = 1'b0;
      bit an;
      bit fin = 1'b0;
      for (int k = 0; k < 2; k++) begin
         repeat (4) order.push_back(2'd1);
         order.push_back(2'd0);
      end
      rst_n = 1'b0;
      tick;
      tick;
      ov0 = n_overlap;
      mdl_next = 32'h0BADF00D;
      if_addr = 25'h0000200;
      d_addr = 25'h1000080; d_we = 1'b0; d_len = 2'd3; d_wdata = '0;
      rst_n = 1'b1;
      if_req = 1'b1;
      d_req = 1'b1;
      for (int cyc = 0; cyc < 600 && post < 3; cyc++) begin
         tick;
         if (if_req && !act) w++;
         an  = (q_start && q_sel == 2'd0) || (act && !qdp);
         qdp = q_done;
         act = an;
         if (q_start) begin
            n_checks++;
            if (order.size() == 0 || q_sel !== order[0])
               $display("FAIL b2b_order grant %0d got sel %0d want %0d",
                        grants, q_sel,
                        order.size() == 0 ? 2'd3 : order[0]);
            else n_pass++;
            if (order.size() != 0) void'(order.pop_front());
            grants++;
         end
         if (fin) post++;
         else if (grants == 10 && if_done) begin
            fin = 1'b1;
            if_req = 1'b0;
            d_req = 1'b0;
         end
      end
      n_checks++;
      if ({fin, grants} !== {1'b1, 32'd10})
         $display("FAIL b2b_grants got %0d/%0d want 1/10", fin, grants);
      else n_pass++;
      n_checks++;
      if (n_overlap !== ov0)
         $display("FAIL b2b_overlap got %0d want %0d", n_overlap, ov0);
      else n_pass++;
`ifdef QSPI_ARB_PERF_EN
      n_checks++;
      if ({perf_d_grants, perf_if_grants} !== {16'd8, 16'd2})
         $display("FAIL perf_grants got %0d/%0d want 8/2",
                  perf_d_grants, perf_if_grants);
      else n_pass++;
      n_checks++;
      if (perf_if_wait !== 16'(w))
         $display("FAIL perf_if_wait got %0d want %0d", perf_if_wait, w);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset;
      test_ifetch;
      test_data;
      test_flash_write;
      test_drop;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
